// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered sequential ALU for the multicycle MIPS core.
//            Logic, add/sub and compare ops complete one cycle after start.
//            A signed multiply (and a signed divide when ALU_SEQ_DIV_EN is
//            defined) iterates for WIDTH cycles behind a start/busy/done
//            handshake. Result and flags are registered together.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous active-high reset
//            start     - launch an operation (sampled when not busy)
//            op[2:0]   - operation select
//            a, b      - signed operands, captured at start
//            busy      - iterative operation in progress
//            done      - one-cycle pulse, result/flags valid from here
//            result    - primary result (low product / quotient)
//            result_hi - high product / remainder, 0 for other ops
//            zero, negative, overflow - flags derived from the operation
// Macro    : ALU_SEQ_DIV_EN - enables the iterative signed divider (op 111)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_RSUB = 3'b011;
    localparam logic [2:0] c_OP_OR   = 3'b100;
    localparam logic [2:0] c_OP_SLT  = 3'b101;
    localparam logic [2:0] c_OP_MUL  = 3'b110;
    localparam logic [2:0] c_OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_hi;       // partial product high part / remainder
    logic [WIDTH-1:0]   r_lo;       // multiplier / dividend-quotient shifter
    logic [WIDTH:0]     r_mcand;    // multiplicand / divisor magnitude
    logic               r_neg_lo;   // sign of product / quotient
    logic               r_done;
    logic [WIDTH-1:0]   r_result, r_result_hi;
    logic               r_zero, r_negative, r_overflow;

    logic               w_out_ld, w_cap, w_ovf;
    logic [WIDTH-1:0]   w_res, w_res_hi;
    logic [WIDTH-1:0]   w_add, w_sub, w_rsub, w_abs_a, w_abs_b;
    logic [WIDTH-1:0]   w_cap_lo;
    logic [WIDTH:0]     w_cap_mcand;
    logic [WIDTH:0]     w_mul_sum, w_nxt_hi;
    logic [WIDTH-1:0]   w_nxt_lo;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;

`ifdef ALU_SEQ_DIV_EN
    logic               r_neg_hi, r_is_div, r_div0, r_divovf;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_quo, w_rem;
`endif

    assign w_add   = a + b;
    assign w_sub   = a - b;
    assign w_rsub  = b - a;
    // Two's complement negation of the most-negative value yields
    // 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Shift-add step: add multiplicand into the high half, shift right.
    assign w_mul_sum = r_hi + (r_lo[0] ? r_mcand : '0);

`ifdef ALU_SEQ_DIV_EN
    // Restoring step: shift remainder left, subtract divisor if it fits.
    assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, r_mcand};
    assign w_ge    = ~w_diff[WIDTH+1];
    assign w_nxt_hi = r_is_div ? (w_ge ? w_diff[WIDTH:0] : w_shift)
                               : {1'b0, w_mul_sum[WIDTH:1]};
    assign w_nxt_lo = r_is_div ? {r_lo[WIDTH-2:0], w_ge}
                               : {w_mul_sum[0], r_lo[WIDTH-1:1]};
    assign w_quo    = r_neg_lo ? (~w_nxt_lo + 1'b1) : w_nxt_lo;
    assign w_rem    = r_neg_hi ? (~w_nxt_hi[WIDTH-1:0] + 1'b1) : w_nxt_hi[WIDTH-1:0];
    assign w_cap_lo    = (op == c_OP_DIV) ? w_abs_a : w_abs_b;
    assign w_cap_mcand = (op == c_OP_DIV) ? {1'b0, w_abs_b} : {1'b0, w_abs_a};
`else
    assign w_nxt_hi    = {1'b0, w_mul_sum[WIDTH:1]};
    assign w_nxt_lo    = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    assign w_cap_lo    = w_abs_b;
    assign w_cap_mcand = {1'b0, w_abs_a};
`endif

    assign w_prod_mag = {w_nxt_hi[WIDTH-1:0], w_nxt_lo};
    assign w_prod     = r_neg_lo ? (~w_prod_mag + 1'b1) : w_prod_mag;

    // Next-state and output-load decode. The FIN cycle is the done cycle of
    // an iterative op, so it accepts a new start exactly like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_out_ld    = 1'b0;
        w_cap       = 1'b0;
        w_res       = '0;
        w_res_hi    = '0;
        w_ovf       = 1'b0;
        case (r_state)
            S_IDLE, S_FIN: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_out_ld = 1'b1;
                    case (op)
                        c_OP_AND:  w_res = a & b;
                        c_OP_ADD: begin
                            w_res = w_add;
                            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
                        end
                        c_OP_SUB: begin
                            w_res = w_sub;
                            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
                        end
                        c_OP_RSUB: begin
                            w_res = w_rsub;
                            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_rsub[WIDTH-1] != b[WIDTH-1]);
                        end
                        c_OP_OR:   w_res = a | b;
                        c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                        c_OP_MUL: begin
                            w_out_ld    = 1'b0;
                            w_cap       = 1'b1;
                            w_state_nxt = S_ITER;
                        end
                        default: begin
`ifdef ALU_SEQ_DIV_EN
                            w_out_ld    = 1'b0;
                            w_cap       = 1'b1;
                            w_state_nxt = S_ITER;
`endif
                        end
                    endcase
                end
            end
            S_ITER: begin
                // The last step and sign correction are folded into the
                // edge that enters FIN so done lands WIDTH+1 cycles after start.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_FIN;
                    w_out_ld    = 1'b1;
                    w_res       = w_prod[WIDTH-1:0];
                    w_res_hi    = w_prod[2*WIDTH-1:WIDTH];
                    w_ovf       = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
`ifdef ALU_SEQ_DIV_EN
                    if (r_is_div) begin
                        w_res    = w_quo;
                        w_res_hi = w_rem;
                        w_ovf    = r_divovf;
                        if (r_div0) begin
                            w_res    = '1;
                            w_res_hi = r_a;
                            w_ovf    = 1'b1;
                        end
                    end
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_mcand     <= '0;
            r_neg_lo    <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_neg_hi    <= 1'b0;
            r_is_div    <= 1'b0;
            r_div0      <= 1'b0;
            r_divovf    <= 1'b0;
            r_a         <= '0;
`endif
        end else begin
            r_done <= w_out_ld;
            if (w_out_ld) begin
                r_result    <= w_res;
                r_result_hi <= w_res_hi;
                r_zero      <= (w_res == '0);
                r_negative  <= w_res[WIDTH-1];
                r_overflow  <= w_ovf;
            end
            if (w_cap) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_hi     <= '0;
                r_lo     <= w_cap_lo;
                r_mcand  <= w_cap_mcand;
                r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_SEQ_DIV_EN
                r_neg_hi <= a[WIDTH-1];
                r_is_div <= (op == c_OP_DIV);
                r_div0   <= (b == '0);
                r_divovf <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                r_a      <= a;
`endif
            end else if (r_state == S_ITER) begin
                r_cnt <= r_cnt - 1'b1;
                r_hi  <= w_nxt_hi;
                r_lo  <= w_nxt_lo;
            end
        end
    end

    assign busy      = (r_state == S_ITER);
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=32). A behavioural model
//            built on 64-bit signed arithmetic predicts each done cycle and
//            its result/flags; a compare process checks every cycle.
// Macro    : ALU_SEQ_DIV_EN - selects the divide model for op 111
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero, negative, overflow;
    logic [W-1:0] result, result_hi;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] held_res = '0, held_hi = '0;
    logic         held_ovf = 1'b0;
    int           busy_lo = -1, busy_hi = -2;
    int           cyc = 0;
    int           tests = 0, fails = 0;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference semantics from plain signed arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] h, output logic v);
        longint sx, sy, t, mx, mn;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        mx = (64'sd1 <<< (W-1)) - 1;
        mn = -(64'sd1 <<< (W-1));
        r = '0; h = '0; v = 1'b0;
        case (o)
            3'd0: r = x & y;
            3'd1: begin t = sx + sy; r = t[W-1:0]; v = (t > mx) || (t < mn); end
            3'd2: begin t = sx - sy; r = t[W-1:0]; v = (t > mx) || (t < mn); end
            3'd3: begin t = sy - sx; r = t[W-1:0]; v = (t > mx) || (t < mn); end
            3'd4: r = x | y;
            3'd5: r = (sx < sy) ? 1 : 0;
            3'd6: begin t = sx * sy; r = t[W-1:0]; h = t[2*W-1:W]; v = (t > mx) || (t < mn); end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                if (sy == 0) begin
                    r = '1; h = x; v = 1'b1;
                end else if (sx == mn && sy == -1) begin
                    r = x; h = '0; v = 1'b1;
                end else begin
                    t = sx / sy; r = t[W-1:0];
                    t = sx % sy; h = t[W-1:0];
                end
`endif
            end
        endcase
    endfunction

    function automatic bit is_long(input logic [2:0] o);
`ifdef ALU_SEQ_DIV_EN
        return o >= 3'd6;
`else
        return o == 3'd6;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the model's predicted done schedule.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            bit exp_done;
            exp_done = (q.size() > 0) && (q[0].cyc == cyc);
            check("done", done, exp_done);
            check("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            if (exp_done) begin
                held_res = q[0].res;
                held_hi  = q[0].hi;
                held_ovf = q[0].ovf;
                void'(q.pop_front());
            end
            check("result", result, held_res);
            check("result_hi", result_hi, held_hi);
            check("zero", zero, held_res == '0);
            check("negative", negative, held_res[W-1]);
            check("overflow", overflow, held_ovf);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (!((cyc >= busy_lo) && (cyc <= busy_hi))) begin
            model(o, x, y, e.res, e.hi, e.ovf);
            if (is_long(o)) begin
                busy_lo = cyc + 1;
                busy_hi = cyc + W;
                e.cyc   = cyc + W + 1;
            end else begin
                e.cyc   = cyc + 1;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() > 0 || cyc <= busy_hi) && k < 200) begin
            idle(1);
            k++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] r, h;
        logic         v;

        // Pin the model itself with hand-computed values.
        model(3'd1, 32'h7FFF_FFFF, 32'h1, r, h, v);
        check("pin_add_res", r, 32'h8000_0000); check("pin_add_ovf", v, 1);
        model(3'd3, 32'd5, 32'd3, r, h, v);
        check("pin_rsub_res", r, 32'hFFFF_FFFE); check("pin_rsub_ovf", v, 0);
        model(3'd6, 32'hFFFF_FFFD, 32'd7, r, h, v);
        check("pin_mul_res", r, 32'hFFFF_FFEB); check("pin_mul_hi", h, 32'hFFFF_FFFF);
        check("pin_mul_ovf", v, 0);
        model(3'd6, 32'h0001_0000, 32'h0001_0000, r, h, v);
        check("pin_mul2_res", r, 32'h0); check("pin_mul2_hi", h, 32'h1); check("pin_mul2_ovf", v, 1);
        model(3'd5, 32'hFFFF_FFFF, 32'h1, r, h, v);
        check("pin_slt", r, 32'h1);
`ifdef ALU_SEQ_DIV_EN
        model(3'd7, 32'hFFFF_FFF9, 32'd2, r, h, v);
        check("pin_div_q", r, 32'hFFFF_FFFD); check("pin_div_r", h, 32'hFFFF_FFFF);
        model(3'd7, 32'd9, 32'd0, r, h, v);
        check("pin_div0_q", r, 32'hFFFF_FFFF); check("pin_div0_ovf", v, 1);
`else
        model(3'd7, 32'd9, 32'd4, r, h, v);
        check("pin_op7", r, 32'h0);
`endif

        // Reset state.
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0); check("rst_done", done, 0);
        check("rst_result", result, 0); check("rst_result_hi", result_hi, 0);
        check("rst_zero", zero, 1); check("rst_negative", negative, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Directed cases.
        issue(3'd1, 32'h7FFF_FFFF, 32'h1);
        issue(3'd3, 32'd5, 32'd3);
        idle(1);
        issue(3'd6, 32'hFFFF_FFFD, 32'd7);
        drain();
        issue(3'd6, 32'h0001_0000, 32'h0001_0000);
        idle(3);
        issue(3'd2, 32'd100, 32'd1);         // ignored while busy
        drain();
        issue(3'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(3'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(3'd5, 32'hFFFF_FFFF, 32'h1);
        issue(3'd7, 32'hFFFF_FFF9, 32'd2);
        drain();
        issue(3'd7, 32'd9, 32'd0);
        drain();
        // Start accepted in the done cycle of a multiply.
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(W);
        issue(3'd1, 32'd2, 32'd3);
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        idle(5);
        #1 reset = 1'b1;
        chk_en = 1'b0;
        #1;
        check("arst_busy", busy, 0); check("arst_done", done, 0);
        check("arst_result", result, 0); check("arst_result_hi", result_hi, 0);
        check("arst_zero", zero, 1); check("arst_overflow", overflow, 0);
        @(negedge clk);
        q.delete();
        busy_lo = -1; busy_hi = -2;
        held_res = '0; held_hi = '0; held_ovf = 1'b0;
        reset = 1'b0; start = 1'b0;
        chk_en = 1'b1;
        idle(40);
        issue(3'd1, 32'd2, 32'd3);
        drain();

        // Randomized traffic, including starts while busy.
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational datapath ALU, for the multicycle MIPS core.
- Single-cycle logic and add/sub ops complete in one clock; a signed multiply (and optionally a divide) runs iteratively over WIDTH cycles.
- Uses a start/busy/done handshake so the control FSM can stall on long ops.
- Flags are registered together with the result.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  3  operation select.
- a  input  WIDTH  signed operand A; captured at start.
- b  input  WIDTH  signed operand B; captured at start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  primary result (low product / quotient).
- result_hi  output  WIDTH  high product / remainder; 0 for other ops.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (see rules).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, result_hi=0, zero=1, negative=0, overflow=0; counter and operand registers cleared.
- Reset mid-operation aborts the op; no done pulse is produced.
- op encoding:
  - 000 AND; 001 ADD; 010 SUB (a-b); 011 RSUB (b-a).
  - 100 OR; 101 SLT (result=1 if a<b signed, else 0).
  - 110 MUL; 111 DIV (optional; see feature).
- States: IDLE, ITER, FIN.
- IDLE, start=1, op in 000..101: compute, register result/flags, done=1 next cycle, remain IDLE. Latency 1; busy stays 0.
- IDLE, start=1, op=110: capture |a|, |b| and product sign; busy=1; enter ITER with counter=WIDTH.
- ITER: one shift-add step per cycle; counter decrements; at counter==1 go to FIN.
- FIN: apply sign correction; load result=low WIDTH bits and result_hi=high WIDTH bits of the signed 2*WIDTH product; done=1, busy=0; return to IDLE.
- MUL latency: done asserted WIDTH+1 cycles after the start cycle.
- done is high for exactly one cycle. result and flags hold until the next done.
- start while busy=1 is ignored; no queuing. start in the same cycle as done (IDLE) is accepted normally.
- Back-to-back single-cycle starts give one done per cycle.
- Overflow:
  - ADD/SUB/RSUB: carry into MSB XOR carry out of MSB, computed on the subtraction/addition actually performed.
  - MUL: 1 when result_hi is not the sign extension of result[WIDTH-1].
  - AND/OR/SLT: 0.
- zero and negative are derived from result only, never from result_hi.
- Arithmetic wraps modulo 2^WIDTH; the most-negative operand to MUL is handled via WIDTH+1-bit magnitude.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: op=111 performs signed restoring division over WIDTH ITER cycles, same latency and handshake as MUL.
  - result=quotient truncated toward zero; result_hi=remainder with the sign of a.
  - b==0: result all ones, result_hi=a, overflow=1.
  - a=most-negative, b=-1: result=a, result_hi=0, overflow=1.
- Not defined: op=111 is a single-cycle op returning result=0, result_hi=0, overflow=0, zero=1; no divider logic is synthesised.

Test Plan:
- Assert reset while ITER with op=110 -> all outputs at reset values immediately (async); no done afterwards; next start ADD 2+3 -> result=5 one cycle later.
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> result=0x80000000, overflow=1, negative=1, done 1 cycle after start; RSUB a=5 b=3 -> result=-2 (0xFFFFFFFE), overflow=0.
- MUL a=-3 b=7 -> done exactly 33 cycles after start; result=0xFFFFFFEB, result_hi=0xFFFFFFFF, overflow=0; busy high for cycles 1..32.
- MUL a=0x10000 b=0x10000 -> result=0, result_hi=1, zero=1, overflow=1.
- Pulse start with SUB while busy during a MUL -> ignored; exactly one done and the MUL result is unchanged; back-to-back AND, OR, SLT(-1<1) -> three consecutive done pulses with results a&b, a|b, 1.
- With ALU_SEQ_DIV_EN: DIV -7/2 -> result=-3, result_hi=-1; DIV by 0 -> result=0xFFFFFFFF, overflow=1. Without the macro: op=111 -> done after 1 cycle, result=0, zero=1.
